// File: rtl/mem_wb_sender.sv
// mem_wb_sender: MEM pipeline stage that holds one instruction, waits for load data and hands the result to WB.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   EX_to_MEM_valid        upstream instruction valid
//   to_MEM_data[100:0]     {pc, dest, alu_result, gr_we, res_from_mem, mem_op[2:0]}
//   MEM_allow_in           stage can accept an instruction this cycle
//   data_sram_data_ok      load data return strobe
//   data_sram_rdata[31:0]  load return word
//   WB_allow_in            downstream accept
//   MEM_to_WB_valid        downstream payload valid
//   to_WB_data[96:0]       {pc, dest, final_result, gr_we}
//   MEM_fwd[37:0]          {fwd_valid, dest[4:0], value}; driven only when MEM_FWD_EN is defined, else zero
module mem_wb_sender (
  input  logic         clk,
  input  logic         resetn,
  input  logic         EX_to_MEM_valid,
  input  logic [100:0] to_MEM_data,
  output logic         MEM_allow_in,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  input  logic         WB_allow_in,
  output logic         MEM_to_WB_valid,
  output logic [96:0]  to_WB_data,
  output logic [37:0]  MEM_fwd
);
  typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;
  state_t         state_q, state_d;
  logic           mem_valid_q, mem_valid_d;
  logic [100:0]   data_q, data_d;
  logic [31:0]    buf_q, buf_d;
  logic           ready_go, capture;
  logic [31:0]    pc, dest, alu, word, load, final_result;
  logic           gr_we, res_from_mem;
  logic [2:0]     mem_op;
  logic [7:0]     byte_v;
  logic [15:0]    half_v;

  assign pc           = data_q[100:69];
  assign dest         = data_q[68:37];
  assign alu          = data_q[36:5];
  assign gr_we        = data_q[4];
  assign res_from_mem = data_q[3];
  assign mem_op       = data_q[2:0];

  always_comb begin
    ready_go        = (state_q == WAIT) ? data_sram_data_ok : 1'b1;
    MEM_allow_in    = ~mem_valid_q | (ready_go & WB_allow_in);
    MEM_to_WB_valid = mem_valid_q & ready_go;
    // HELD replays the captured word so the output stays stable while WB stalls
    word            = (state_q == HELD) ? buf_q : data_sram_rdata;
    byte_v          = alu[1] ? (alu[0] ? word[31:24] : word[23:16]) : (alu[0] ? word[15:8] : word[7:0]);
    half_v          = alu[1] ? word[31:16] : word[15:0];
    load            = (mem_op == 3'd1) ? {{24{byte_v[7]}}, byte_v} :
                      (mem_op == 3'd2) ? {{16{half_v[15]}}, half_v} :
                      (mem_op == 3'd3) ? {24'b0, byte_v} :
                      (mem_op == 3'd4) ? {16'b0, half_v} : word;
    final_result    = res_from_mem ? load : alu;
    to_WB_data      = {pc, dest, final_result, gr_we};
  end

  always_comb begin
    // data_ok counts only for a live load that WB cannot take right now
    capture     = (state_q == WAIT) & mem_valid_q & data_sram_data_ok & ~WB_allow_in;
    mem_valid_d = MEM_allow_in ? EX_to_MEM_valid : mem_valid_q;
    data_d      = MEM_allow_in ? to_MEM_data : data_q;
    buf_d       = capture ? data_sram_rdata : buf_q;
    state_d     = MEM_allow_in ? ((EX_to_MEM_valid & to_MEM_data[3]) ? WAIT : IDLE) :
                  capture ? HELD : state_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      data_q      <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      data_q      <= data_d;
      buf_q       <= buf_d;
    end
  end

`ifdef MEM_FWD_EN
  assign MEM_fwd = {mem_valid_q & gr_we & (dest[4:0] != 5'd0) & ready_go, dest[4:0], final_result};
`else
  assign MEM_fwd = 38'b0;
`endif
endmodule

// File: tb/tb_mem_wb_sender.sv
// tb_mem_wb_sender: scoreboard bench for mem_wb_sender covering latency, load extraction, hold, back-to-back and reset.
module tb_mem_wb_sender;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ex_v = 1'b0;
  logic [100:0] tmd = '0;
  logic         dok = 1'b0;
  logic [31:0]  rd = '0;
  logic         wba = 1'b1;
  logic         allow, v;
  logic [96:0]  wbd;
  logic [37:0]  fwd;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [96:0]  q[$];

  always #5 clk = ~clk;

  mem_wb_sender dut (
    .clk(clk), .resetn(resetn), .EX_to_MEM_valid(ex_v), .to_MEM_data(tmd),
    .MEM_allow_in(allow), .data_sram_data_ok(dok), .data_sram_rdata(rd),
    .WB_allow_in(wba), .MEM_to_WB_valid(v), .to_WB_data(wbd), .MEM_fwd(fwd)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [2:0] op, input logic [1:0] a, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = r[7:0];
      2'd1:    b = r[15:8];
      2'd2:    b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (op)
      3'd1:    ext = {{24{b[7]}}, b};
      3'd2:    ext = {{16{h[15]}}, h};
      3'd3:    ext = {24'b0, b};
      3'd4:    ext = {16'b0, h};
      default: ext = r;
    endcase
  endfunction

  always @(negedge clk) begin
    if (resetn && v) begin
      if (q.size() == 0) chk("unexpected_out", v, 1'b0);
      else if (wba) chk("out", wbd, q.pop_front());
      else chk("hold", wbd, q[0]);
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] dest, input logic [31:0] alu,
                       input logic gr, input logic rfm, input logic [2:0] op, input logic [31:0] rdata);
    bit ok = 1'b0;
    q.push_back({pc, dest, rfm ? ext(op, alu[1:0], rdata) : alu, gr});
    ex_v = 1'b1;
    tmd  = {pc, dest, alu, gr, rfm, op};
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = allow;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", allow, 1'b1);
    ex_v = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal;
  end

  initial begin
    step;
    step;
    chk("rst_valid", v, 1'b0);
    chk("rst_allow", allow, 1'b1);
    chk("rst_data", wbd, 97'b0);
    chk("rst_fwd", fwd, 38'b0);
    resetn = 1'b1;
    step;

    issue(32'h100, 32'd5, 32'h0000_1234, 1'b1, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    chk("nl_valid", v, 1'b1);
    chk("nl_result", wbd[32:1], 32'h0000_1234);
`ifdef MEM_FWD_EN
    chk("nl_fwd", fwd, {1'b1, 5'd5, 32'h0000_1234});
`else
    chk("nl_fwd_off", fwd, 38'b0);
`endif
    step;

    issue(32'h104, 32'd6, 32'h0000_1003, 1'b1, 1'b1, 3'd1, 32'h80FF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ldb_stall", allow, 1'b0);
      chk("ldb_novalid", v, 1'b0);
      step;
    end
    dok = 1'b1;
    rd  = 32'h80FF_FFFF;
    @(negedge clk);
    chk("ldb_valid", v, 1'b1);
    chk("ldb_result", wbd[32:1], 32'hFFFF_FF80);
    step;
    dok = 1'b0;

    wba = 1'b0;
    issue(32'h108, 32'd7, 32'h0000_2002, 1'b1, 1'b1, 3'd4, 32'hBEEF_0000);
    dok = 1'b1;
    rd  = 32'hBEEF_0000;
    @(negedge clk);
    chk("ldhu_stall", allow, 1'b0);
    step;
    dok = 1'b0;
    rd  = 32'h1234_5678;
    @(negedge clk);
    chk("held_valid", v, 1'b1);
    chk("held_result", wbd[32:1], 32'h0000_BEEF);
    step;
    wba = 1'b1;
    @(negedge clk);
    chk("held_release", allow, 1'b1);
    step;
    dok = 1'b1;
    @(negedge clk);
    chk("spurious_ok_idle", v, 1'b0);
    step;
    dok = 1'b0;

    for (int k = 0; k < 4; k++) begin
      q.push_back({32'h200 + 32'(4 * k), 32'd9, 32'hA000 + 32'(k), 1'b1});
      ex_v = 1'b1;
      tmd  = {32'h200 + 32'(4 * k), 32'd9, 32'hA000 + 32'(k), 1'b1, 1'b0, 3'd0};
      @(negedge clk);
      if (k > 0) chk("b2b_valid", v, 1'b1);
      chk("b2b_accept", allow, 1'b1);
      step;
    end
    ex_v = 1'b0;
    @(negedge clk);
    chk("b2b_last", v, 1'b1);
    step;

    issue(32'h300, 32'd3, 32'h0000_0010, 1'b1, 1'b1, 3'd0, 32'hCAFE_F00D);
    step;
    dok = 1'b1;
    rd  = 32'hCAFE_F00D;
    issue(32'h304, 32'd4, 32'h0000_5555, 1'b1, 1'b0, 3'd0, 32'h0);
    dok = 1'b0;
    @(negedge clk);
    chk("overlap_next", v, 1'b1);
    step;

    for (int op = 0; op < 8; op++) begin
      logic [31:0] a, r;
      a = $urandom;
      r = $urandom;
      issue(32'h400 + 32'(4 * op), 32'd11, a, 1'b1, 1'b1, 3'(op), r);
      dok = 1'b1;
      rd  = r;
      @(negedge clk);
      chk("op_valid", v, 1'b1);
      step;
      dok = 1'b0;
    end

`ifdef MEM_FWD_EN
    issue(32'h500, 32'd0, 32'h0000_0777, 1'b1, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    chk("fwd_dest0", fwd[37], 1'b0);
    step;
    issue(32'h504, 32'd7, 32'h0000_0777, 1'b1, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    chk("fwd_dest7", fwd, {1'b1, 5'd7, 32'h0000_0777});
    step;
`endif

    issue(32'h600, 32'd8, 32'h0000_0020, 1'b1, 1'b1, 3'd0, 32'h0BAD_0BAD);
    step;
    resetn = 1'b0;
    q.delete();
    #1;
    chk("rst_wait_valid", v, 1'b0);
    chk("rst_wait_allow", allow, 1'b1);
    step;
    resetn = 1'b1;
    dok = 1'b1;
    rd  = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("post_rst_valid", v, 1'b0);
    chk("post_rst_allow", allow, 1'b1);
    step;
    dok = 1'b0;
    @(negedge clk);
    chk("post_rst_quiet", v, 1'b0);
    step;
    step;
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_wb_sender.md
MEM_WB_SENDER -- requirements
Module: mem_wb_sender

Interface
REQ-001 SHALL expose `clk`, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL expose `resetn`, input, 1: asynchronous, active-low reset.
REQ-003 SHALL expose `EX_to_MEM_valid`, input, 1: upstream instruction valid.
REQ-004 SHALL expose `to_MEM_data`, input, 101: {pc[31:0], dest[31:0], alu_result[31:0], gr_we, res_from_mem, mem_op[2:0]}, MSB first.
REQ-005 SHALL expose `MEM_allow_in`, output, 1: stage can accept an instruction this cycle.
REQ-006 SHALL expose `data_sram_data_ok`, input, 1: load data return strobe.
REQ-007 SHALL expose `data_sram_rdata`, input, 32: load return word.
REQ-008 SHALL expose `WB_allow_in`, input, 1: downstream accept.
REQ-009 SHALL expose `MEM_to_WB_valid`, output, 1: downstream payload valid.
REQ-010 SHALL expose `to_WB_data`, output, 97: {pc[31:0], dest[31:0], final_result[31:0], gr_we}, MSB first.
REQ-011 SHALL expose `MEM_fwd`, output, 38: {fwd_valid, dest[4:0], value[31:0]}, present only per REQ-028.

Function
REQ-012 SHALL register `to_MEM_data` and set MEM_valid on every cycle where `MEM_allow_in` is high; MEM_valid takes `EX_to_MEM_valid`.
REQ-013 SHALL drive `MEM_allow_in` = ~MEM_valid | (MEM_ready_go & `WB_allow_in`).
REQ-014 SHALL drive `MEM_to_WB_valid` = MEM_valid & MEM_ready_go.
REQ-015 SHALL keep a state machine with states IDLE, WAIT and HELD:
- Non-load accepted (res_from_mem=0): -> IDLE.
- Load accepted: -> WAIT.
- WAIT, `data_sram_data_ok` high, `WB_allow_in` low: -> HELD, capturing `data_sram_rdata`.
- WAIT, `data_sram_data_ok` high, `WB_allow_in` high: pass through combinationally; next state set by REQ-012.
- HELD, `WB_allow_in` high: leave; next state set by REQ-012.
REQ-016 MEM_ready_go SHALL be 1 in IDLE, `data_sram_data_ok` in WAIT, and 1 in HELD.
REQ-017 Non-load latency: payload SHALL be offered in the cycle after acceptance.
REQ-018 Load latency: payload SHALL be offered in the same cycle `data_sram_data_ok` is high.
REQ-019 `data_sram_data_ok` SHALL be ignored outside WAIT, and in WAIT when MEM_valid is low.
REQ-020 Load word source SHALL be `data_sram_rdata` in WAIT and the captured buffer in HELD.
REQ-021 Load extraction SHALL follow mem_op:
- 000 ld.w: word.
- 001 ld.b: byte at alu_result[1:0], sign-extended.
- 010 ld.h: half at alu_result[1], sign-extended.
- 011 ld.bu: byte, zero-extended.
- 100 ld.hu: half, zero-extended.
- Other codes: word.
REQ-022 final_result SHALL be the extracted load value when res_from_mem=1, else alu_result.
REQ-023 While `MEM_to_WB_valid` is high and `WB_allow_in` is low, `to_WB_data` SHALL remain stable.
REQ-024 When WB accepts and a new instruction is accepted in the same cycle, the new instruction SHALL replace the old without a bubble.

Reset
REQ-025 On `resetn` low, asynchronously:
- MEM_valid=0, state=IDLE, payload and capture registers=0.
- Hence `MEM_to_WB_valid`=0, `MEM_allow_in`=1, `to_WB_data`=0, `MEM_fwd`=0.
REQ-026 Reset asserted mid-WAIT or mid-HELD SHALL discard the in-flight load.
REQ-027 A `data_sram_data_ok` arriving after reset release SHALL be ignored per REQ-019.

Configuration
REQ-028 With macro MEM_FWD_EN defined:
- `MEM_fwd` = {MEM_valid & gr_we & (dest[4:0]!=0) & MEM_ready_go, dest[4:0], final_result}.
- MEM_FWD_EN undefined: `MEM_fwd` tied to 38'b0, with no added logic.

Verification
REQ-029 Non-load, alu_result=0x0000_1234, gr_we=1, dest=5, `WB_allow_in`=1 -> next cycle `MEM_to_WB_valid`=1, final_result=0x0000_1234.
REQ-030 ld.b, alu_result[1:0]=2'b11, rdata=0x80FF_FFFF, data_ok after 3 cycles -> `MEM_allow_in`=0 for 3 cycles, then final_result=0xFFFF_FF80.
REQ-031 ld.hu, alu_result[1]=1, rdata=0xBEEF_0000, data_ok while `WB_allow_in`=0 -> state HELD, output stable; with `WB_allow_in`=1 next cycle -> final_result=0x0000_BEEF.
REQ-032 Back-to-back non-loads with `WB_allow_in` held high -> one output per cycle, no bubbles, pc order preserved.
REQ-033 resetn pulsed low during WAIT, then spurious data_ok -> `MEM_to_WB_valid` stays 0 and `MEM_allow_in`=1.
REQ-034 MEM_FWD_EN defined, gr_we=1, dest=0 -> fwd_valid=0; dest=7 -> fwd_valid=1, value=final_result.
